// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: fetch, load/store and memory-side signals
// of the shared instruction/data memory arbiter.
interface riscv_mem_arbiter_if;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_addr;
    logic        f_resp_valid;
    logic [31:0] f_rdata;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_addr;
    logic        d_we;
    logic [31:0] d_wdata;
    logic        d_resp_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  f_valid, f_addr,
        input  d_valid, d_addr, d_we, d_wdata,
        input  mem_rdata,
        output f_ready, f_resp_valid, f_rdata,
        output d_ready, d_resp_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output f_valid, f_addr,
        output d_valid, d_addr, d_we, d_wdata,
        output mem_rdata,
        input  f_ready, f_resp_valid, f_rdata,
        input  d_ready, d_resp_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: round-robin sharing of one single-port memory
// between instruction fetch and load/store, fixed access latency.
module riscv_mem_arbiter #(
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    riscv_mem_arbiter_if.master bus
);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_nx;
    logic          rr_last;
    logic          gnt_d;
    logic          accept;
    logic          req_d;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [31:0]   f_rdata_q;
    logic [31:0]   d_rdata_q;
    logic [CW-1:0] cnt;

    // rr_last==1 means data went last, so fetch wins a tie
    assign gnt_d  = bus.d_valid && (!bus.f_valid || !rr_last);
    assign accept = (state == IDLE) && (bus.f_valid || bus.d_valid);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.f_ready      = 1'b0;
        bus.d_ready      = 1'b0;
        bus.f_resp_valid = 1'b0;
        bus.d_resp_valid = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        unique case (state)
            IDLE: begin
                bus.f_ready = bus.f_valid && !gnt_d;
                bus.d_ready = gnt_d;
            end
            ISSUE: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = req_we;
                bus.mem_addr  = req_addr;
                bus.mem_wdata = req_wdata;
            end
            RESP: begin
                bus.f_resp_valid = !req_d;
                bus.d_resp_valid = req_d;
            end
            default: ;
        endcase
    end

    assign bus.f_rdata = f_rdata_q;
    assign bus.d_rdata = d_rdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_last   <= 1'b1;
            req_d     <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            cnt       <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (accept) begin
                rr_last   <= gnt_d;
                req_d     <= gnt_d;
                req_we    <= gnt_d && bus.d_we;
                req_addr  <= gnt_d ? bus.d_addr : bus.f_addr;
                req_wdata <= gnt_d ? bus.d_wdata : '0;
            end
            if (state == ISSUE)
                cnt <= CW'(MEM_LATENCY - 1);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            // stores acknowledge with zero instead of memory data
            if (state == WAIT && cnt == '0) begin
                if (req_d) d_rdata_q <= req_we ? '0 : bus.mem_rdata;
                else       f_rdata_q <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed table, corner sequences and
// randomized traffic against a transaction-timeline model.
module tb_riscv_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   mon_on = 1'b0;

    riscv_mem_arbiter_if a ();
    riscv_mem_arbiter_if b ();

    riscv_mem_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(a)
    );
    riscv_mem_arbiter #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .bus(b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] mem_a [bit [31:0]];
    logic [31:0] mem_b [bit [31:0]];

    function automatic logic [31:0] rd_a(logic [31:0] ad);
        return mem_a.exists(ad) ? mem_a[ad] : (ad ^ 32'hA5C3_0F00);
    endfunction

    function automatic logic [31:0] rd_b(logic [31:0] ad);
        return mem_b.exists(ad) ? mem_b[ad] : (ad ^ 32'hA5C3_0F00);
    endfunction

    // memory models: data valid only in the cycle LATENCY after mem_en
    int          pend_a = 0;
    int          pend_b = 0;
    logic [31:0] pdat_a;
    logic [31:0] pdat_b;

    always @(negedge clk) begin
        bit hit;
        hit = 1'b0;
        if (pend_a > 0) begin
            pend_a--;
            hit = (pend_a == 0);
        end
        a.mem_rdata = hit ? pdat_a : (32'hBAD0_0000 | 32'(cyc[15:0]));
        if (a.mem_en) begin
            if (a.mem_we) mem_a[a.mem_addr] = a.mem_wdata;
            else begin
                pend_a = 1;
                pdat_a = rd_a(a.mem_addr);
            end
        end
    end

    always @(negedge clk) begin
        bit hit;
        hit = 1'b0;
        if (pend_b > 0) begin
            pend_b--;
            hit = (pend_b == 0);
        end
        b.mem_rdata = hit ? pdat_b : (32'hBAD1_0000 | 32'(cyc[15:0]));
        if (b.mem_en) begin
            if (b.mem_we) mem_b[b.mem_addr] = b.mem_wdata;
            else begin
                pend_b = 3;
                pdat_b = rd_b(b.mem_addr);
            end
        end
    end

    // timeline model: one outstanding transaction, events at fixed offsets
    bit          m_act = 1'b0;
    int          m_t = 0;
    bit          m_src = 1'b0;
    bit          m_we = 1'b0;
    bit          m_rr = 1'b1;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_exp = '0;
    logic [31:0] m_frd = '0;
    logic [31:0] m_drd = '0;

    always @(negedge clk) begin
        bit ef, ed, em, er;
        if (mon_on) begin
            ef = !m_act && a.f_valid && (!a.d_valid || m_rr);
            ed = !m_act && a.d_valid && (!a.f_valid || !m_rr);
            em = m_act && (cyc == m_t + 1);
            er = m_act && (cyc == m_t + 3);
            check("mon_f_ready", a.f_ready, ef);
            check("mon_d_ready", a.d_ready, ed);
            check("mon_mem_en", a.mem_en, em);
            if (em) begin
                check("mon_mem_we", a.mem_we, m_we);
                check("mon_mem_addr", a.mem_addr, m_addr);
                if (m_we) check("mon_mem_wdata", a.mem_wdata, m_wd);
            end
            if (er) begin
                if (m_src) m_drd = m_exp;
                else       m_frd = m_exp;
            end
            check("mon_f_resp", a.f_resp_valid, er && !m_src);
            check("mon_d_resp", a.d_resp_valid, er && m_src);
            check("mon_f_rdata", a.f_rdata, m_frd);
            check("mon_d_rdata", a.d_rdata, m_drd);
            if (er) m_act = 1'b0;
            if (!reset) begin
                m_act = 1'b0;
                m_rr  = 1'b1;
                m_frd = '0;
                m_drd = '0;
            end else if (ef || ed) begin
                m_act  = 1'b1;
                m_t    = cyc;
                m_src  = ed;
                m_we   = ed && a.d_we;
                m_addr = ed ? a.d_addr : a.f_addr;
                m_wd   = a.d_wdata;
                m_exp  = m_we ? 32'h0 : rd_a(m_addr);
                m_rr   = ed;
            end
        end
    end

    typedef struct {
        bit          fv, dv, we;
        logic [31:0] fa, da, wd;
        bit          xf, xd;
        logic [31:0] xaddr;
        bit          xwe;
        logic [31:0] xwd, xrd;
    } vec_t;

    vec_t tbl [6];

    task automatic clr();
        a.f_valid = 0; a.f_addr = 0; a.d_valid = 0;
        a.d_addr = 0; a.d_we = 0; a.d_wdata = 0;
        b.f_valid = 0; b.f_addr = 0; b.d_valid = 0;
        b.d_addr = 0; b.d_we = 0; b.d_wdata = 0;
    endtask

    initial begin
        tbl[0] = '{1, 0, 0, 32'h10, 32'h0, 32'h0, 1, 0,
                   32'h10, 0, 32'h0, 32'hDEADBEEF};
        tbl[1] = '{0, 1, 1, 32'h0, 32'h100, 32'h12345678, 0, 1,
                   32'h100, 1, 32'h12345678, 32'h0};
        tbl[2] = '{0, 1, 0, 32'h0, 32'h100, 32'h0, 0, 1,
                   32'h100, 0, 32'h0, 32'h12345678};
        tbl[3] = '{1, 1, 0, 32'h200, 32'h300, 32'h0, 1, 0,
                   32'h200, 0, 32'h0, 32'hCAFE0200};
        tbl[4] = '{1, 1, 0, 32'h200, 32'h300, 32'h0, 0, 1,
                   32'h300, 0, 32'h0, 32'h0BAD0300};
        tbl[5] = '{1, 0, 1, 32'h13, 32'h500, 32'hFFFF, 1, 0,
                   32'h13, 0, 32'h0, 32'h11223344};
        mem_a[32'h10]  = 32'hDEADBEEF;
        mem_a[32'h200] = 32'hCAFE0200;
        mem_a[32'h300] = 32'h0BAD0300;
        mem_a[32'h13]  = 32'h11223344;
        mem_b[32'h20]  = 32'h20202020;

        reset = 1'b0;
        clr();
        tick();
        tick();
        mon_on = 1'b1;
        @(negedge clk);
        check("rst_f_ready", a.f_ready, 0);
        check("rst_d_ready", a.d_ready, 0);
        check("rst_f_resp", a.f_resp_valid, 0);
        check("rst_d_resp", a.d_resp_valid, 0);
        check("rst_f_rdata", a.f_rdata, 0);
        check("rst_d_rdata", a.d_rdata, 0);
        check("rst_mem_en", a.mem_en, 0);
        check("rst_mem_we", a.mem_we, 0);
        check("rst_mem_addr", a.mem_addr, 0);
        check("rst_mem_wdata", a.mem_wdata, 0);
        tick();
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            tick();
            a.f_valid = tbl[i].fv;
            a.d_valid = tbl[i].dv;
            a.d_we    = tbl[i].we;
            a.f_addr  = tbl[i].fa;
            a.d_addr  = tbl[i].da;
            a.d_wdata = tbl[i].wd;
            @(negedge clk);
            check("tbl_f_ready", a.f_ready, tbl[i].xf);
            check("tbl_d_ready", a.d_ready, tbl[i].xd);
            tick();
            a.f_valid = 0;
            a.d_valid = 0;
            a.f_addr  = $urandom;
            a.d_addr  = $urandom;
            a.d_wdata = $urandom;
            a.d_we    = 1'($urandom);
            @(negedge clk);
            check("tbl_mem_en", a.mem_en, 1);
            check("tbl_mem_addr", a.mem_addr, tbl[i].xaddr);
            check("tbl_mem_we", a.mem_we, tbl[i].xwe);
            if (tbl[i].xwe) check("tbl_mem_wdata", a.mem_wdata, tbl[i].xwd);
            tick();
            tick();
            @(negedge clk);
            check("tbl_f_resp", a.f_resp_valid, tbl[i].xf);
            check("tbl_d_resp", a.d_resp_valid, tbl[i].xd);
            check("tbl_rdata", tbl[i].xd ? a.d_rdata : a.f_rdata, tbl[i].xrd);
        end

        // both requesters valid straight out of reset, held for 6 grants
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        a.f_valid = 1; a.f_addr = 32'h10;
        a.d_valid = 1; a.d_addr = 32'h100; a.d_we = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            check("rr_f_ready", a.f_ready, (k % 8) == 0);
            check("rr_d_ready", a.d_ready, (k % 8) == 4);
            tick();
        end
        a.f_valid = 0;
        a.d_valid = 0;

        // reset during WAIT of a load
        a.d_valid = 1; a.d_we = 0; a.d_addr = 32'h100;
        @(negedge clk);
        check("mid_d_ready", a.d_ready, 1);
        tick();
        a.d_valid = 0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("mid_d_resp", a.d_resp_valid, 0);
        check("mid_mem_en", a.mem_en, 0);
        check("mid_d_rdata", a.d_rdata, 0);
        check("mid_f_rdata", a.f_rdata, 0);
        tick();
        @(negedge clk);
        check("mid_d_resp2", a.d_resp_valid, 0);
        check("mid_mem_en2", a.mem_en, 0);
        tick();
        a.f_valid = 1; a.f_addr = 32'h10;
        a.d_valid = 1; a.d_addr = 32'h300; a.d_we = 0;
        @(negedge clk);
        check("post_f_ready", a.f_ready, 1);
        check("post_d_ready", a.d_ready, 0);
        tick();
        a.f_valid = 0;
        tick();
        tick();
        @(negedge clk);
        check("post_f_resp", a.f_resp_valid, 1);
        check("post_f_rdata", a.f_rdata, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check("post_d_ready2", a.d_ready, 1);
        tick();
        a.d_valid = 0;
        repeat (3) tick();

        for (int n = 0; n < 400; n++) begin
            tick();
            reset     = ($urandom_range(0, 63) != 0);
            a.f_valid = ($urandom_range(0, 99) < 55);
            a.d_valid = ($urandom_range(0, 99) < 55);
            a.f_addr  = 32'h400 + 32'($urandom_range(0, 7)) * 4;
            a.d_addr  = 32'h400 + 32'($urandom_range(0, 7)) * 4;
            a.d_we    = 1'($urandom);
            a.d_wdata = $urandom;
        end
        tick();
        reset = 1'b1;
        clr();
        repeat (6) tick();

        // MEM_LATENCY=3 instance, fetch held valid across two accepts
        b.f_valid = 1; b.f_addr = 32'h20;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("l3_f_ready", b.f_ready, k == 0 || k == 6);
            check("l3_mem_en", b.mem_en, k == 1);
            check("l3_f_resp", b.f_resp_valid, k == 5);
            if (k == 1) check("l3_mem_addr", b.mem_addr, 32'h20);
            if (k == 5) check("l3_f_rdata", b.f_rdata, 32'h20202020);
            tick();
        end
        b.f_valid = 0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
